angle_unwrap_track: RTL and testbench

Downstream stage of the filtered CORDIC angle calculator. Consumes each valid first-quadrant angle plus its quadrant code and expands it to a full-turn angle. It unwraps successive samples into a multi-turn position and counts revolutions. It also produces a windowed speed estimate and rejects implausible jumps, with a resynchronisation state machine.

---
 rtl/angle_pkg.sv | 28 ++
 rtl/angle_quad_expand.sv | 61 ++++++
 rtl/angle_unwrap_track.sv | 198 +++++++++++++++++++
 tb/tb_angle_unwrap_track.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/angle_pkg.sv
// rtl/angle_pkg.sv - shared constants, widths and tracker state encoding
package angle_pkg;

    // Angle scale: a quarter turn is pi/2 * 2^15 LSBs
    localparam int QUARTER_TURN = 51472;
    localparam int HALF_TURN    = 2 * QUARTER_TURN;
    localparam int FULL_TURN    = 4 * QUARTER_TURN;

    // Default tracker tuning
    localparam int MAX_STEP_DEF    = 8192;
    localparam int FAULT_LIMIT_DEF = 4;
    localparam int WIN_LOG2_DEF    = 4;
    localparam int POS_W_DEF       = 32;

    // Datapath widths
    localparam int THETA_W = 17;
    localparam int ANGLE_W = 18;
    localparam int DELTA_W = 19;
    localparam int TURNS_W = 16;

    // Tracker states: no reference yet, tracking, waiting for a fresh reference
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } track_state_e;

endpackage

// File: rtl/angle_quad_expand.sv
// rtl/angle_quad_expand.sv - registered first-quadrant to full-turn angle expansion
module angle_quad_expand
    import angle_pkg::*;
#(
    parameter int QUARTER = QUARTER_TURN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      drop,
    input  logic signed [THETA_W-1:0] theta_1st_quad,
    input  logic [1:0]                quadrant,
    input  logic                      angle_valid,
    output logic [ANGLE_W-1:0]        angle_full,
    output logic                      full_valid
);

    localparam logic [DELTA_W-1:0] Q_U = DELTA_W'(QUARTER);
    localparam logic [DELTA_W-1:0] H_U = DELTA_W'(2 * QUARTER);
    localparam logic [DELTA_W-1:0] F_U = DELTA_W'(4 * QUARTER);

    logic [DELTA_W-1:0] theta_c;
    logic [DELTA_W-1:0] a_sum;
    logic [ANGLE_W-1:0] a_next;

    // Clamp theta into 0..QUARTER, then fold by quadrant; exactly one full turn wraps to 0
    always_comb begin
        theta_c = {2'b00, theta_1st_quad};
        if (theta_1st_quad[THETA_W-1]) begin
            theta_c = '0;
        end else if (theta_c > Q_U) begin
            theta_c = Q_U;
        end

        case (quadrant)
            2'd0:    a_sum = theta_c;
            2'd1:    a_sum = H_U - theta_c;
            2'd2:    a_sum = H_U + theta_c;
            default: a_sum = F_U - theta_c;
        endcase

        if (a_sum == F_U) begin
            a_next = '0;
        end else begin
            a_next = ANGLE_W'(a_sum);
        end
    end

    // Register the expanded angle; a dropped sample leaves the last angle in place
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            angle_full <= '0;
            full_valid <= 1'b0;
        end else begin
            full_valid <= angle_valid && !drop;
            if (angle_valid && !drop) begin
                angle_full <= a_next;
            end
        end
    end

endmodule

// File: rtl/angle_unwrap_track.sv
// rtl/angle_unwrap_track.sv - full-turn expansion, multi-turn unwrap, plausibility check and speed window
module angle_unwrap_track
    import angle_pkg::*;
#(
    parameter int QUARTER     = QUARTER_TURN,
    parameter int MAX_STEP    = MAX_STEP_DEF,
    parameter int FAULT_LIMIT = FAULT_LIMIT_DEF,
    parameter int WIN_LOG2    = WIN_LOG2_DEF,
    parameter int POS_W       = POS_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic signed [16:0]        theta_1st_quad,
    input  logic [1:0]                quadrant,
    input  logic                      angle_valid,
    output logic [17:0]               angle_full,
    output logic signed [POS_W-1:0]   pos_acc,
    output logic signed [15:0]        turns,
    output logic                      track_valid,
    output logic signed [POS_W-1:0]   speed,
    output logic                      speed_valid,
    output logic                      fault,
    output logic                      resync
);

    localparam int REJ_W = $clog2(FAULT_LIMIT + 1);

    localparam logic signed [DELTA_W-1:0] HALF_S = DELTA_W'(2 * QUARTER);
    localparam logic signed [DELTA_W-1:0] FULL_S = DELTA_W'(4 * QUARTER);
    localparam logic signed [DELTA_W-1:0] STEP_S = DELTA_W'(MAX_STEP);
    localparam logic [REJ_W-1:0]          REJ_LAST = REJ_W'(FAULT_LIMIT - 1);

    track_state_e state;
    track_state_e state_next;

    logic [ANGLE_W-1:0]        a_cur;
    logic                      a_valid;
    logic [ANGLE_W-1:0]        a_prev;

    logic signed [DELTA_W-1:0] d_raw;
    logic signed [DELTA_W-1:0] d_corr;
    logic signed [DELTA_W-1:0] d_mag;
    logic                      turn_inc;
    logic                      turn_dec;
    logic                      too_big;
    logic signed [POS_W-1:0]   d_ext;

    logic [REJ_W-1:0]          rej_cnt;
    logic signed [POS_W-1:0]   win_sum;
    logic [WIN_LOG2-1:0]       win_cnt;

    logic                      take_ref;
    logic                      accept;
    logic                      reject;

    angle_quad_expand #(
        .QUARTER (QUARTER)
    ) u_expand (
        .clk            (clk),
        .rst_n          (rst_n),
        .drop           (clr),
        .theta_1st_quad (theta_1st_quad),
        .quadrant       (quadrant),
        .angle_valid    (angle_valid),
        .angle_full     (a_cur),
        .full_valid     (a_valid)
    );

    assign angle_full = a_cur;

    // Shortest-path delta against the reference angle, with turn crossing and step magnitude check
    always_comb begin
        d_raw    = $signed({1'b0, a_cur}) - $signed({1'b0, a_prev});
        d_corr   = d_raw;
        turn_inc = 1'b0;
        turn_dec = 1'b0;
        if (d_raw > HALF_S) begin
            d_corr   = d_raw - FULL_S;
            turn_dec = 1'b1;
        end else if (d_raw < -HALF_S) begin
            d_corr   = d_raw + FULL_S;
            turn_inc = 1'b1;
        end
        d_mag   = d_corr[DELTA_W-1] ? -d_corr : d_corr;
        too_big = d_mag > STEP_S;
        d_ext   = POS_W'(d_corr);
    end

    // Tracker state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Classify each expanded sample as reference, accepted or rejected and pick the next state
    always_comb begin
        state_next = state;
        take_ref   = 1'b0;
        accept     = 1'b0;
        reject     = 1'b0;
        if (clr) begin
            state_next = IDLE;
        end else if (a_valid) begin
            case (state)
                TRACK: begin
                    if (too_big) begin
                        reject = 1'b1;
                        if (rej_cnt >= REJ_LAST) begin
                            state_next = RESYNC;
                        end
                    end else begin
                        accept = 1'b1;
                    end
                end
                default: begin
                    take_ref   = 1'b1;
                    state_next = TRACK;
                end
            endcase
        end
    end

    // Reference angle, multi-turn position, revolution count and output strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_prev      <= '0;
            pos_acc     <= '0;
            turns       <= '0;
            track_valid <= 1'b0;
            resync      <= 1'b0;
        end else begin
            track_valid <= take_ref | accept;
            resync      <= take_ref;
            if (clr) begin
                pos_acc <= '0;
                turns   <= '0;
            end else if (take_ref) begin
                a_prev <= a_cur;
            end else if (accept) begin
                a_prev  <= a_cur;
                pos_acc <= pos_acc + d_ext;
                if (turn_inc) begin
                    turns <= turns + 16'sd1;
                end else if (turn_dec) begin
                    turns <= turns - 16'sd1;
                end
            end
        end
    end

    // Consecutive-reject counter and sticky fault flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rej_cnt <= '0;
            fault   <= 1'b0;
        end else if (clr) begin
            rej_cnt <= '0;
            fault   <= 1'b0;
        end else if (take_ref || accept) begin
            rej_cnt <= '0;
        end else if (reject) begin
            rej_cnt <= rej_cnt + REJ_W'(1);
            fault   <= 1'b1;
        end
    end

    // Sum accepted deltas over a fixed count of samples and publish the total as speed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_sum     <= '0;
            win_cnt     <= '0;
            speed       <= '0;
            speed_valid <= 1'b0;
        end else begin
            speed_valid <= 1'b0;
            if (clr) begin
                win_sum <= '0;
                win_cnt <= '0;
                speed   <= '0;
            end else if (accept) begin
                if (&win_cnt) begin
                    speed       <= win_sum + d_ext;
                    speed_valid <= 1'b1;
                    win_sum     <= '0;
                    win_cnt     <= '0;
                end else begin
                    win_sum <= win_sum + d_ext;
                    win_cnt <= win_cnt + WIN_LOG2'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_angle_unwrap_track.sv
// tb/tb_angle_unwrap_track.sv - self-checking bench for angle_unwrap_track
module tb_angle_unwrap_track;

    localparam int QUARTER     = 51472;
    localparam int HALF        = 2 * QUARTER;
    localparam int FULL        = 4 * QUARTER;
    localparam int MAX_STEP    = 8192;
    localparam int FAULT_LIMIT = 4;
    localparam int WIN         = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clr;
    logic signed [16:0] theta_1st_quad;
    logic [1:0]         quadrant;
    logic               angle_valid;
    logic [17:0]        angle_full;
    logic signed [31:0] pos_acc;
    logic signed [15:0] turns;
    logic               track_valid;
    logic signed [31:0] speed;
    logic               speed_valid;
    logic               fault;
    logic               resync;

    always #5 clk = ~clk;

    angle_unwrap_track dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (clr),
        .theta_1st_quad (theta_1st_quad),
        .quadrant       (quadrant),
        .angle_valid    (angle_valid),
        .angle_full     (angle_full),
        .pos_acc        (pos_acc),
        .turns          (turns),
        .track_valid    (track_valid),
        .speed          (speed),
        .speed_valid    (speed_valid),
        .fault          (fault),
        .resync         (resync)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;

    typedef struct {
        int due;
        int a;
    } ang_t;

    typedef struct {
        int due;
        bit tv;
        bit rs;
        bit sv;
        int pos;
        int trn;
        int spd;
        bit flt;
    } trk_t;

    ang_t ang_q[$];
    trk_t trk_q[$];

    bit need_ref = 1'b1;
    int m_prev   = 0;
    int m_pos    = 0;
    int m_turns  = 0;
    int m_speed  = 0;
    int m_rej    = 0;
    bit m_fault  = 1'b0;
    int win_q[$];

    task automatic check(string name, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int expand(int q, int th);
        int t;
        int a;
        t = (th < 0) ? 0 : ((th > QUARTER) ? QUARTER : th);
        case (q)
            0:       a = t;
            1:       a = HALF - t;
            2:       a = HALF + t;
            default: a = FULL - t;
        endcase
        return (a == FULL) ? 0 : a;
    endfunction

    task automatic model_sample(int q, int th);
        int   a;
        int   d;
        int   t;
        ang_t g;
        trk_t r;
        a = expand(q, th);
        g.due = cyc + 1;
        g.a   = a;
        ang_q.push_back(g);
        r.due = cyc + 2;
        r.tv  = 1'b0;
        r.rs  = 1'b0;
        r.sv  = 1'b0;
        if (need_ref) begin
            m_prev   = a;
            need_ref = 1'b0;
            m_rej    = 0;
            r.tv     = 1'b1;
            r.rs     = 1'b1;
        end else begin
            d = a - m_prev;
            t = 0;
            if (d > HALF) begin
                d = d - FULL;
                t = -1;
            end else if (d < -HALF) begin
                d = d + FULL;
                t = 1;
            end
            if (d > MAX_STEP || d < -MAX_STEP) begin
                m_fault = 1'b1;
                m_rej++;
                if (m_rej >= FAULT_LIMIT) need_ref = 1'b1;
            end else begin
                m_prev  = a;
                m_pos   = m_pos + d;
                m_turns = m_turns + t;
                m_rej   = 0;
                r.tv    = 1'b1;
                win_q.push_back(d);
                if (win_q.size() == WIN) begin
                    m_speed = win_q.sum();
                    r.sv    = 1'b1;
                    win_q.delete();
                end
            end
        end
        r.pos = m_pos;
        r.trn = m_turns;
        r.spd = m_speed;
        r.flt = m_fault;
        trk_q.push_back(r);
    endtask

    // clr or reset applied at the next edge: in-flight results vanish, state goes to zero
    task automatic model_clear(bit full);
        ang_t g;
        trk_t r;
        while (trk_q.size() > 0 && trk_q[trk_q.size()-1].due >= cyc + 1)
            trk_q.delete(trk_q.size() - 1);
        if (full) begin
            ang_q.delete();
            g.due = cyc + 1;
            g.a   = 0;
            ang_q.push_back(g);
        end
        need_ref = 1'b1;
        m_prev   = 0;
        m_pos    = 0;
        m_turns  = 0;
        m_speed  = 0;
        m_rej    = 0;
        m_fault  = 1'b0;
        win_q.delete();
        r.due = cyc + 1;
        r.tv  = 1'b0;
        r.rs  = 1'b0;
        r.sv  = 1'b0;
        r.pos = 0;
        r.trn = 0;
        r.spd = 0;
        r.flt = 1'b0;
        trk_q.push_back(r);
    endtask

    // Every-cycle comparison of all outputs against the model's visible state
    initial begin : cmp
        int   c_ang;
        int   c_pos;
        int   c_trn;
        int   c_spd;
        bit   c_flt;
        bit   e_tv;
        bit   e_rs;
        bit   e_sv;
        ang_t g;
        trk_t r;
        c_ang = 0;
        c_pos = 0;
        c_trn = 0;
        c_spd = 0;
        c_flt = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (checking) begin
                e_tv = 1'b0;
                e_rs = 1'b0;
                e_sv = 1'b0;
                if (ang_q.size() > 0 && ang_q[0].due == cyc) begin
                    g = ang_q.pop_front();
                    c_ang = g.a;
                end
                if (trk_q.size() > 0 && trk_q[0].due == cyc) begin
                    r = trk_q.pop_front();
                    e_tv  = r.tv;
                    e_rs  = r.rs;
                    e_sv  = r.sv;
                    c_pos = r.pos;
                    c_trn = r.trn;
                    c_spd = r.spd;
                    c_flt = r.flt;
                end
                check("track_valid", track_valid, e_tv);
                check("resync", resync, e_rs);
                check("speed_valid", speed_valid, e_sv);
                check("angle_full", angle_full, c_ang);
                check("pos_acc", pos_acc, c_pos);
                check("turns", turns, c_trn);
                check("speed", speed, c_spd);
                check("fault", fault, c_flt);
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(int q, int th);
        quadrant       = 2'(q);
        theta_1st_quad = 17'(th);
        angle_valid    = 1'b1;
        model_sample(q, th);
        @(negedge clk);
        angle_valid = 1'b0;
    endtask

    task automatic do_clr(bit with_sample, int q, int th);
        clr = 1'b1;
        if (with_sample) begin
            quadrant       = 2'(q);
            theta_1st_quad = 17'(th);
            angle_valid    = 1'b1;
        end
        model_clear(1'b0);
        @(negedge clk);
        clr         = 1'b0;
        angle_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n          = 1'b0;
        clr            = 1'b0;
        angle_valid    = 1'b0;
        quadrant       = 2'd0;
        theta_1st_quad = '0;
        step(3);
        rst_n    = 1'b1;
        checking = 1'b1;
        step(2);

        check("rst_angle_full", angle_full, 0);
        check("rst_pos_acc", pos_acc, 0);
        check("rst_turns", turns, 0);
        check("rst_speed", speed, 0);
        check("rst_track_valid", track_valid, 0);
        check("rst_speed_valid", speed_valid, 0);
        check("rst_fault", fault, 0);
        check("rst_resync", resync, 0);

        // First sample after reset is a reference
        send(1, 1000);
        check("t1_angle_full", angle_full, 101944);
        step();
        check("t1_resync", resync, 1);
        check("t1_track_valid", track_valid, 1);
        check("t1_pos_acc", pos_acc, 0);
        step(10);

        // Forward crossing of zero counts one turn
        do_clr(1'b0, 0, 0);
        step(2);
        send(3, 888);
        check("t2_ref_angle", angle_full, 205000);
        step(12);
        send(0, 500);
        step();
        check("t2_turns", turns, 1);
        check("t2_pos_acc", pos_acc, 1388);
        check("t2_track_valid", track_valid, 1);
        check("t2_model_pos", m_pos, 1388);
        step(10);

        // Oversized jumps rejected; FAULT_LIMIT of them force a resync
        do_clr(1'b0, 0, 0);
        step(2);
        send(0, 100);
        step(12);
        for (int i = 0; i < FAULT_LIMIT; i++) begin
            send(0, 20000);
            step();
            check("t3_reject_no_track", track_valid, 0);
            check("t3_reject_fault", fault, 1);
            check("t3_reject_pos", pos_acc, 0);
            step(10);
        end
        send(0, 30000);
        step();
        check("t3_resync", resync, 1);
        check("t3_resync_pos", pos_acc, 0);
        step(10);
        send(0, 30100);
        step();
        check("t3_after_resync_pos", pos_acc, 100);
        check("t3_fault_sticky", fault, 1);
        step(10);

        // Clamping, full-turn wrap and the exact MAX_STEP boundary
        do_clr(1'b0, 0, 0);
        step(2);
        send(3, 0);
        check("t4_q3_zero_wraps", angle_full, 0);
        step(12);
        send(0, -5);
        check("t4_neg_clamp", angle_full, 0);
        step(12);
        send(0, 8192);
        step();
        check("t4_step_max_ok", pos_acc, 8192);
        step(10);
        send(0, 16385);
        step();
        check("t4_step_over_rej", track_valid, 0);
        check("t4_step_over_fault", fault, 1);
        step(10);
        send(0, 16384);
        step();
        check("t4_step_after_rej", pos_acc, 16384);
        step(10);
        send(0, 60000);
        check("t4_high_clamp", angle_full, 51472);
        step(12);

        // Back-to-back accepted samples fill one speed window
        do_clr(1'b0, 0, 0);
        step(2);
        send(0, 1000);
        for (int i = 1; i <= WIN; i++) send(0, 1000 + 100 * i);
        step();
        check("t5_speed_valid", speed_valid, 1);
        check("t5_speed", speed, 1600);
        check("t5_pos", pos_acc, 1600);
        step(10);

        // Reset between a sample's strobe and its result discards it
        send(0, 2700);
        do_reset();
        check("t6_no_track", track_valid, 0);
        check("t6_pos_reset", pos_acc, 0);
        check("t6_angle_reset", angle_full, 0);
        check("t6_speed_reset", speed, 0);
        step(5);
        send(0, 500);
        step();
        check("t6_ref_after_reset", resync, 1);
        step(10);

        // clr wins over a simultaneous sample
        send(0, 600);
        step(12);
        send(0, 20000);
        step(12);
        do_clr(1'b1, 0, 700);
        step();
        check("t7_pos_clr", pos_acc, 0);
        check("t7_turns_clr", turns, 0);
        check("t7_fault_clr", fault, 0);
        check("t7_angle_kept", angle_full, 20000);
        step(10);
        send(0, 9000);
        step();
        check("t7_ref_after_clr", resync, 1);
        check("t7_track_after_clr", track_valid, 1);
        step(5);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
